// File: rtl/sump2_event_cond.sv
// sump2_event_cond: configurable event-input front end for the SUMP2 capture
// path. Synchronises raw event pins, applies per-channel invert, glitch filter
// and enable mask, and generates a programmable sample-enable pulse. All
// configuration registers sit on the Mesa local bus in the capture clock domain.
module sump2_event_cond #(
   parameter int unsigned CH_BITS     = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_BITS   = 4,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0040
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               lb_wr,
   input  logic               lb_rd,
   input  logic [31:0]        lb_addr,
   input  logic [31:0]        lb_wr_d,
   output logic [31:0]        lb_rd_d,
   output logic               lb_rd_rdy,
   input  logic [CH_BITS-1:0] events_raw,
   output logic [CH_BITS-1:0] events_out,
   output logic               sample_en,
   output logic               edge_any
);

   localparam logic [FILT_BITS-1:0] ONE_F = 1;
   localparam logic [FILT_BITS:0]   ONE_W = 1;

   // configuration registers
   logic                 r_en;
   logic [FILT_BITS-1:0] r_thresh;
   logic [CH_BITS-1:0]   r_inv;
   logic [CH_BITS-1:0]   r_mask;
   logic [15:0]          r_div;

   // datapath state
   logic [SYNC_STAGES-1:0][CH_BITS-1:0] r_sync;
   logic [CH_BITS-1:0]                  r_st;
   logic [CH_BITS-1:0][FILT_BITS-1:0]   r_cnt;
   logic [CH_BITS-1:0]                  r_events;
   logic                                r_edge;
   logic [15:0]                         r_dcnt;
   logic                                r_sample;

   // read pipeline
   logic        r_rd_pend;
   logic [31:0] r_rd_hold;
   logic        r_rd_rdy;
   logic [31:0] r_rd_d;

   // decode and datapath wires
   logic [31:0]                       w_off;
   logic [2:0]                        w_idx;
   logic                              w_hit;
   logic                              w_wr_ctrl;
   logic                              w_wr_inv;
   logic                              w_wr_mask;
   logic                              w_wr_div;
   logic [31:0]                       w_rd_mux;
   logic [CH_BITS-1:0]                w_sync;
   logic [FILT_BITS-1:0]              w_thr;
   logic [CH_BITS-1:0]                w_st_nxt;
   logic [CH_BITS-1:0][FILT_BITS-1:0] w_cnt_nxt;
   logic [CH_BITS-1:0][FILT_BITS:0]   w_inc;
   logic [CH_BITS-1:0]                w_ev_nxt;
   logic                              w_unused;

   // Offsets 0..4 only; anything below BASE_ADDR wraps to a huge offset and misses.
   assign w_off     = lb_addr - BASE_ADDR;
   assign w_idx     = w_off[4:2];
   assign w_hit     = (w_off[31:5] == '0) && (w_off[1:0] == 2'b00) && (w_idx <= 3'd4);
   assign w_wr_ctrl = lb_wr && w_hit && (w_idx == 3'd0);
   assign w_wr_inv  = lb_wr && w_hit && (w_idx == 3'd1);
   assign w_wr_mask = lb_wr && w_hit && (w_idx == 3'd2);
   assign w_wr_div  = lb_wr && w_hit && (w_idx == 3'd3);
   assign w_unused  = ^lb_wr_d;

   // Register file writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en     <= 1'b1;
         r_thresh <= '0;
         r_inv    <= '0;
         r_mask   <= '1;
         r_div    <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_en     <= lb_wr_d[0];
            r_thresh <= lb_wr_d[8 +: FILT_BITS];
         end
         if (w_wr_inv)  r_inv  <= lb_wr_d[CH_BITS-1:0];
         if (w_wr_mask) r_mask <= lb_wr_d[CH_BITS-1:0];
         if (w_wr_div)  r_div  <= lb_wr_d[15:0];
      end
   end

   // Read mux over current register contents (pre-write on a same-edge write)
   always_comb begin
      w_rd_mux = '0;
      case (w_idx)
         3'd0: begin
            w_rd_mux[0]              = r_en;
            w_rd_mux[8 +: FILT_BITS] = r_thresh;
         end
         3'd1:    w_rd_mux[CH_BITS-1:0] = r_inv;
         3'd2:    w_rd_mux[CH_BITS-1:0] = r_mask;
         3'd3:    w_rd_mux[15:0]        = r_div;
         3'd4:    w_rd_mux[CH_BITS-1:0] = r_events;
         default: w_rd_mux = '0;
      endcase
   end

   // Two-stage read: capture on the lb_rd edge, present for one cycle after the next
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pend <= 1'b0;
         r_rd_hold <= '0;
         r_rd_rdy  <= 1'b0;
         r_rd_d    <= '0;
      end else begin
         r_rd_pend <= lb_rd && w_hit;
         r_rd_hold <= w_rd_mux;
         r_rd_rdy  <= r_rd_pend;
         r_rd_d    <= r_rd_pend ? r_rd_hold : '0;
      end
   end

   // Input synchroniser chain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= events_raw;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1] ^ r_inv;
   assign w_thr  = (r_thresh == '0) ? ONE_F : r_thresh;

   // Glitch filter next state: a mismatch must persist w_thr cycles to flip st
   always_comb begin
      w_st_nxt  = r_st;
      w_cnt_nxt = '0;
      w_inc     = '0;
      for (int unsigned i = 0; i < CH_BITS; i++) begin
         w_inc[i] = {1'b0, r_cnt[i]} + ONE_W;
         if (w_sync[i] != r_st[i]) begin
            if (w_inc[i] >= {1'b0, w_thr}) begin
               w_st_nxt[i] = w_sync[i];
            end else begin
               w_cnt_nxt[i] = w_inc[i][FILT_BITS-1:0];
            end
         end
      end
   end

   // Filter state; a CTRL write restarts every count but keeps the settled state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_st  <= '0;
         r_cnt <= '0;
      end else if (w_wr_ctrl) begin
         r_cnt <= '0;
      end else begin
         r_st  <= w_st_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign w_ev_nxt = r_en ? (r_st & r_mask) : '0;

   // Output event register and change detect, aligned to the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_events <= '0;
         r_edge   <= 1'b0;
      end else begin
         r_events <= w_ev_nxt;
         r_edge   <= |(w_ev_nxt ^ r_events);
      end
   end

   // Sample-enable divider: one pulse every DIV+1 cycles while enabled
   always_ff @(posedge clk) begin
      if (reset || w_wr_div || !r_en) begin
         r_dcnt   <= '0;
         r_sample <= 1'b0;
      end else if (r_dcnt == r_div) begin
         r_dcnt   <= '0;
         r_sample <= 1'b1;
      end else begin
         r_dcnt   <= r_dcnt + 16'd1;
         r_sample <= 1'b0;
      end
   end

   assign events_out = r_events;
   assign edge_any   = r_edge;
   assign sample_en  = r_sample;
   assign lb_rd_rdy  = r_rd_rdy;
   assign lb_rd_d    = r_rd_d;

endmodule

// File: tb/tb_sump2_event_cond.sv
// tb_sump2_event_cond: directed self-checking bench for sump2_event_cond.
// Register access is driven from a vector table; event latency, filtering,
// divider and reset behaviour use short hand-written sequences.
module tb_sump2_event_cond;

   localparam int unsigned CH     = 24;
   localparam logic [31:0] BASE   = 32'h0000_0040;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_INV  = BASE + 32'd4;
   localparam logic [31:0] A_MASK = BASE + 32'd8;
   localparam logic [31:0] A_DIV  = BASE + 32'd12;
   localparam logic [31:0] A_LIVE = BASE + 32'd16;
   localparam logic [31:0] A_OFF5 = BASE + 32'd20;
   localparam logic [31:0] A_BELOW = BASE - 32'd4;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      bit          exp_rdy;
   } bus_vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          lb_wr = 1'b0;
   logic          lb_rd = 1'b0;
   logic [31:0]   lb_addr = '0;
   logic [31:0]   lb_wr_d = '0;
   logic [31:0]   lb_rd_d;
   logic          lb_rd_rdy;
   logic [CH-1:0] events_raw = '0;
   logic [CH-1:0] events_out;
   logic          sample_en;
   logic          edge_any;

   int n_tests = 0;
   int n_fail  = 0;

   bus_vec_t tbl[21];

   always #5 clk = ~clk;

   sump2_event_cond #(
      .CH_BITS     (CH),
      .SYNC_STAGES (2),
      .FILT_BITS   (4),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .lb_wr      (lb_wr),
      .lb_rd      (lb_rd),
      .lb_addr    (lb_addr),
      .lb_wr_d    (lb_wr_d),
      .lb_rd_d    (lb_rd_d),
      .lb_rd_rdy  (lb_rd_rdy),
      .events_raw (events_raw),
      .events_out (events_out),
      .sample_en  (sample_en),
      .edge_any   (edge_any)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      lb_wr   = 1'b1;
      lb_addr = a;
      lb_wr_d = d;
      tick();
      lb_wr   = 1'b0;
   endtask

   task automatic bus_read(input string name, input logic [31:0] a, input bit exp_rdy,
                           input logic [31:0] exp_d, input bit also_wr, input logic [31:0] wd);
      lb_rd   = 1'b1;
      lb_wr   = also_wr;
      lb_addr = a;
      lb_wr_d = wd;
      tick();
      lb_rd = 1'b0;
      lb_wr = 1'b0;
      check({name, " rdy@k"}, 32'(lb_rd_rdy), 32'd0);
      tick();
      check({name, " rdy@k+1"}, 32'(lb_rd_rdy), 32'(exp_rdy));
      check({name, " data"}, lb_rd_d, exp_rdy ? exp_d : 32'd0);
      tick();
      check({name, " rdy@k+2"}, 32'(lb_rd_rdy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b0, A_CTRL,  32'h0000_0001, 1'b1};
      tbl[1]  = '{1'b0, A_INV,   32'h0000_00FF, 1'b1};
      tbl[2]  = '{1'b0, A_MASK,  32'h0000_000F, 1'b1};
      tbl[3]  = '{1'b0, A_LIVE,  32'h0000_000F, 1'b1};
      tbl[4]  = '{1'b1, A_INV,   32'hFFFF_FFFF, 1'b0};
      tbl[5]  = '{1'b0, A_INV,   32'h00FF_FFFF, 1'b1};
      tbl[6]  = '{1'b1, A_LIVE,  32'h1234_5678, 1'b0};
      tbl[7]  = '{1'b0, A_LIVE,  32'h0000_000F, 1'b1};
      tbl[8]  = '{1'b1, A_CTRL,  32'hFFFF_FFFF, 1'b0};
      tbl[9]  = '{1'b0, A_CTRL,  32'h0000_0F01, 1'b1};
      tbl[10] = '{1'b1, A_CTRL,  32'h0000_0001, 1'b0};
      tbl[11] = '{1'b1, A_DIV,   32'hFFFF_1234, 1'b0};
      tbl[12] = '{1'b0, A_DIV,   32'h0000_1234, 1'b1};
      tbl[13] = '{1'b1, A_MASK,  32'hFFFF_FFFF, 1'b0};
      tbl[14] = '{1'b0, A_MASK,  32'h00FF_FFFF, 1'b1};
      tbl[15] = '{1'b0, A_OFF5,  32'h0000_0000, 1'b0};
      tbl[16] = '{1'b0, A_BELOW, 32'h0000_0000, 1'b0};
      tbl[17] = '{1'b1, A_OFF5,  32'h0000_5A5A, 1'b0};
      tbl[18] = '{1'b0, A_INV,   32'h00FF_FFFF, 1'b1};
      tbl[19] = '{1'b1, A_INV,   32'h0000_0000, 1'b0};
      tbl[20] = '{1'b1, A_DIV,   32'h0000_0000, 1'b0};

      // reset state
      repeat (3) tick();
      check("rst events_out", 32'(events_out), 32'd0);
      check("rst edge_any", 32'(edge_any), 32'd0);
      check("rst sample_en", 32'(sample_en), 32'd0);
      check("rst lb_rd_rdy", 32'(lb_rd_rdy), 32'd0);
      check("rst lb_rd_d", lb_rd_d, 32'd0);

      // release reset and step inputs after the same edge: output 4 edges later
      reset      = 1'b0;
      events_raw = 24'h00_00A5;
      for (int c = 1; c <= 6; c++) begin
         tick();
         check($sformatf("lat sample_en c%0d", c), 32'(sample_en), 32'd1);
         check($sformatf("lat events_out c%0d", c), 32'(events_out), (c >= 4) ? 32'h0000_00A5 : 32'd0);
         check($sformatf("lat edge_any c%0d", c), 32'(edge_any), (c == 4) ? 32'd1 : 32'd0);
      end

      // THRESH=5: a 4-cycle pulse on ch3 is filtered out
      bus_write(A_CTRL, 32'h0000_0501);
      events_raw = 24'h00_00AD;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 4) events_raw = 24'h00_00A5;
         check($sformatf("glitch events_out c%0d", c), 32'(events_out), 32'h0000_00A5);
      end
      // a sustained level appears 2+5+1 edges later
      events_raw = 24'h00_00AD;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check($sformatf("thr events_out c%0d", c), 32'(events_out), (c == 8) ? 32'h0000_00AD : 32'h0000_00A5);
         check($sformatf("thr edge_any c%0d", c), 32'(edge_any), (c == 8) ? 32'd1 : 32'd0);
      end

      // invert and mask with inputs low
      bus_write(A_CTRL, 32'h0000_0001);
      events_raw = '0;
      repeat (6) tick();
      check("zero events_out", 32'(events_out), 32'd0);
      bus_write(A_INV, 32'h0000_00FF);
      bus_write(A_MASK, 32'h0000_000F);
      repeat (6) tick();
      check("invmask events_out", 32'(events_out), 32'h0000_000F);
      bus_read("rd LIVE", A_LIVE, 1'b1, 32'h0000_000F, 1'b0, 32'd0);

      // register vector table
      for (int i = 0; i < 21; i++) begin
         if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
         else bus_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp_rdy, tbl[i].data, 1'b0, 32'd0);
      end

      // divider: DIV=3 gives a pulse every 4th cycle, first 4 cycles after the write
      events_raw = 24'h00_00A5;
      repeat (6) tick();
      check("div pre events_out", 32'(events_out), 32'h0000_00A5);
      bus_write(A_DIV, 32'h0000_0003);
      check("div w sample_en", 32'(sample_en), 32'd0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         check($sformatf("div sample_en c%0d", c), 32'(sample_en), (c % 4 == 0) ? 32'd1 : 32'd0);
      end

      // EN=0 stops sampling and blanks events from the next cycle
      bus_write(A_CTRL, 32'h0000_0000);
      for (int c = 1; c <= 5; c++) begin
         tick();
         check($sformatf("dis sample_en c%0d", c), 32'(sample_en), 32'd0);
         check($sformatf("dis events_out c%0d", c), 32'(events_out), 32'd0);
         check($sformatf("dis edge_any c%0d", c), 32'(edge_any), (c == 1) ? 32'd1 : 32'd0);
      end
      bus_write(A_CTRL, 32'h0000_0001);

      // read while writing the same register returns the old value
      bus_read("rdwr DIV", A_DIV, 1'b1, 32'h0000_0003, 1'b1, 32'h0000_0009);
      bus_read("rd DIV new", A_DIV, 1'b1, 32'h0000_0009, 1'b0, 32'd0);

      // mid-stream reset with an in-flight read
      bus_write(A_DIV, 32'h0000_0007);
      bus_write(A_CTRL, 32'h0000_0301);
      events_raw = 24'h00_005A;
      repeat (10) tick();
      lb_rd   = 1'b1;
      lb_addr = A_CTRL;
      tick();
      lb_rd = 1'b0;
      reset = 1'b1;
      tick();
      check("mrst lb_rd_rdy", 32'(lb_rd_rdy), 32'd0);
      check("mrst lb_rd_d", lb_rd_d, 32'd0);
      check("mrst events_out", 32'(events_out), 32'd0);
      check("mrst edge_any", 32'(edge_any), 32'd0);
      check("mrst sample_en", 32'(sample_en), 32'd0);
      tick();
      check("mrst lb_rd_rdy 2", 32'(lb_rd_rdy), 32'd0);
      reset = 1'b0;
      tick();
      check("post sample_en", 32'(sample_en), 32'd1);
      check("post events_out", 32'(events_out), 32'd0);
      bus_read("post CTRL", A_CTRL, 1'b1, 32'h0000_0001, 1'b0, 32'd0);
      bus_read("post INV", A_INV, 1'b1, 32'h0000_0000, 1'b0, 32'd0);
      bus_read("post MASK", A_MASK, 1'b1, 32'h00FF_FFFF, 1'b0, 32'd0);
      bus_read("post DIV", A_DIV, 1'b1, 32'h0000_0000, 1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
